mux_n_pipe: RTL and testbench
=============================

MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width in bits (legal range 1..64).
REQ-002 The module SHALL have parameter NUM_IN, default 4, giving the number of data inputs (legal range 2..16).
REQ-003 The module SHALL have parameter SEL_W, default 2, giving the select width; its value SHALL equal ceil(log2(NUM_IN)).
REQ-004 The module SHALL have parameter DEFAULT_VAL, default 0, a WIDTH-bit value output for an out-of-range select.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on the rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The module SHALL have port d_in, input, NUM_IN*WIDTH bits; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-008 The module SHALL have port sel, input, SEL_W bits, the index of the selected input.
REQ-009 The module SHALL have port in_valid, input, 1 bit, qualifying d_in and sel.
REQ-010 The module SHALL have port in_ready, output, 1 bit, indicating the block can accept a beat.
REQ-011 The module SHALL have port out_data, output, WIDTH bits, the selected data at the buffer head.
REQ-012 The module SHALL have port out_valid, output, 1 bit, qualifying out_data.
REQ-013 The module SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-014 The module SHALL have port flush, input, 1 bit, a synchronous discard of all buffered beats.
REQ-015 The module SHALL have port sel_err, output, 1 bit, a sticky flag for an out-of-range select.
REQ-016 The module SHALL have port clr_err, input, 1 bit, a synchronous clear of sel_err.

Function
REQ-017 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; it SHALL be transferred out on a rising edge where out_valid=1 and out_ready=1.
REQ-018 At acceptance the module SHALL capture d_in slice sel when sel<NUM_IN, and DEFAULT_VAL otherwise.
REQ-019 Storage SHALL be a 2-entry FIFO skid buffer with states EMPTY, ONE and FULL, tracked by a count of 0..2.
REQ-020 in_ready SHALL be driven from registered state only: in_ready=1 in EMPTY and ONE, and in_ready=0 in FULL.
REQ-021 Latency SHALL be 1 cycle: a beat accepted in EMPTY SHALL appear with out_valid=1 from the next cycle.
REQ-022 out_valid SHALL be 1 exactly when count>0, and out_data SHALL present the oldest entry; order SHALL be strictly FIFO.
REQ-023 A simultaneous accept and transfer in ONE SHALL leave count at 1, with the new beat becoming the head.
REQ-024 A simultaneous accept and transfer in FULL SHALL not occur, because in_ready=0 in FULL.
REQ-025 The state transitions SHALL be:
- EMPTY to ONE on accept;
- ONE to FULL on accept without transfer;
- ONE to EMPTY on transfer without accept;
- FULL to ONE on transfer.
REQ-026 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-027 flush=1 SHALL set count=0 at the next edge, so out_valid=0 and in_ready=1 the following cycle.
REQ-028 Any beat offered in the flush cycle SHALL be discarded even if in_ready=1, and SHALL NOT set sel_err.
REQ-029 flush SHALL have priority over accept and transfer; a transfer handshake occurring in the flush cycle SHALL still count as delivered downstream.
REQ-030 sel_err SHALL be set at an accept with sel>=NUM_IN and held until clr_err=1.
REQ-031 If the clr_err edge coincides with a new out-of-range accept, set SHALL win and sel_err SHALL remain 1.
REQ-032 In-range sel SHALL never change sel_err.
REQ-033 Both buffer entries SHALL be WIDTH bits with no truncation or extension of selected data.

Reset
REQ-034 While rst=1, the module SHALL force count=0, so out_valid=0, in_ready=0, out_data=DEFAULT_VAL and sel_err=0, independent of clk.
REQ-035 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-operation SHALL discard all buffered beats, with no partial output after release.
REQ-037 No beat SHALL be accepted while rst=1.

Verification
REQ-038 The bench SHALL cover this case: WIDTH=32, NUM_IN=4, d_in slices 0x11,0x22,0x33,0x44, sel=2, in_valid for 1 cycle, out_ready=1 -> out_data=0x33 and out_valid=1 for exactly 1 cycle, 1 cycle after accept.
REQ-039 The bench SHALL cover this case: NUM_IN=3, sel=3 accepted -> out_data=DEFAULT_VAL and sel_err=1 until clr_err; with clr_err and another sel=3 accept on the same edge -> sel_err stays 1.
REQ-040 The bench SHALL cover this case: out_ready=0, push beats A then B, then offer C -> in_ready=0 after B and C is not accepted; raise out_ready -> A then B are delivered in order.
REQ-041 The bench SHALL cover this case: continuous in_valid with out_ready=1 and sel cycling 0..3 -> one beat per cycle, count stays 1 and in_ready stays 1.
REQ-042 The bench SHALL cover this case: FULL state, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered beat is never output.
REQ-043 The bench SHALL cover this case: rst asserted asynchronously between edges while FULL -> out_valid, in_ready and sel_err go to 0 immediately; after release the first out_data comes from a new beat.

Source files
------------

// File: rtl/mux_n_pipe.sv
// N-input selector feeding a 2-entry skid FIFO with valid/ready on both sides.
// Out-of-range selects capture DEFAULT_VAL and raise a sticky sel_err.
module mux_n_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] d_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  input  logic                    clr_err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head_q, tail_q, head_nxt, tail_nxt, pick;
  logic             sel_oor, acc, xfer, rdy_q, err_q;

  always_comb begin
    pick    = DEFAULT_VAL;
    sel_oor = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        pick    = d_in[k*WIDTH +: WIDTH];
        sel_oor = 1'b0;
      end
    end
  end

  // Flush masks the accept so a beat offered alongside it never lands or flags.
  assign acc       = in_valid & rdy_q & ~flush;
  assign xfer      = out_valid & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? head_q : DEFAULT_VAL;
  assign sel_err   = err_q;

  always_comb begin
    state_nxt = state;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    case (state)
      EMPTY: if (acc) begin
        head_nxt  = pick;
        state_nxt = ONE;
      end
      ONE: begin
        if (acc && xfer) begin
          head_nxt = pick;
        end else if (acc) begin
          tail_nxt  = pick;
          state_nxt = FULL;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (xfer) begin
        head_nxt  = tail_q;
        state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      head_q <= DEFAULT_VAL;
      tail_q <= DEFAULT_VAL;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      head_q <= head_nxt;
      tail_q <= tail_nxt;
      // Registered ready: look ahead at the next state so it is exact each cycle.
      rdy_q  <= (state_nxt != FULL);
      if (acc && sel_oor) err_q <= 1'b1;
      else if (clr_err)   err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-input and a 3-input instance share clock and reset.
module tb_mux_n_pipe;
  localparam int W = 32;
  localparam logic [W-1:0] DEF4 = 32'hA5A5_A5A5;
  localparam logic [W-1:0] DEF3 = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4*W-1:0] d_in;
  logic [1:0]     sel;
  logic           in_valid, in_ready, out_valid, out_ready, flush, sel_err, clr_err;
  logic [W-1:0]   out_data;

  logic [3*W-1:0] d3;
  logic [1:0]     s3;
  logic           iv3, ir3, ov3, or3, fl3, se3, clr3;
  logic [W-1:0]   od3;

  int checks = 0;
  int errors = 0;

  mux_n_pipe #(.WIDTH(W), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(DEF4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .sel_err(sel_err), .clr_err(clr_err));

  mux_n_pipe #(.WIDTH(W), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(DEF3)) dut3 (
    .clk(clk), .rst(rst), .d_in(d3), .sel(s3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .flush(fl3),
    .sel_err(se3), .clr_err(clr3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_data !== DEF4) begin errors++; $display("FAIL rst_out_data got %h want %h", out_data, DEF4); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err got %b want 0", sel_err); end
    checks++; if (od3 !== DEF3) begin errors++; $display("FAIL rst_out_data3 got %h want %h", od3, DEF3); end
    tick;
    rst = 1'b0;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single;
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h33) begin errors++; $display("FAIL single_data got %h want 00000033", out_data); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", out_valid); end
  endtask

  task automatic test_sel_err;
    s3 = 2'd3; iv3 = 1'b1; or3 = 1'b0;
    tick;
    iv3 = 1'b0;
    checks++; if (od3 !== DEF3) begin errors++; $display("FAIL oor_data got %h want %h", od3, DEF3); end
    checks++; if (se3 !== 1'b1) begin errors++; $display("FAIL oor_set got %b want 1", se3); end
    tick;
    checks++; if (se3 !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b want 1", se3); end
    clr3 = 1'b1; iv3 = 1'b1; s3 = 2'd3;
    tick;
    clr3 = 1'b0; iv3 = 1'b0;
    checks++; if (se3 !== 1'b1) begin errors++; $display("FAIL oor_set_wins got %b want 1", se3); end
    clr3 = 1'b1;
    tick;
    clr3 = 1'b0;
    checks++; if (se3 !== 1'b0) begin errors++; $display("FAIL oor_clear got %b want 0", se3); end
    or3 = 1'b1;
    tick;
    tick;
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL oor_drain got %b want 0", ov3); end
    s3 = 2'd1; iv3 = 1'b1;
    tick;
    iv3 = 1'b0;
    checks++; if (od3 !== 32'h0000_0222) begin errors++; $display("FAIL inrange_data got %h want 00000222", od3); end
    checks++; if (se3 !== 1'b0) begin errors++; $display("FAIL inrange_no_err got %b want 0", se3); end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    sel = 2'd0; in_valid = 1'b1;
    tick;
    sel = 2'd1;
    tick;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL bp_head got %h want 00000011", out_data); end
    sel = 2'd3;
    tick;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_ready got %b want 0", in_ready); end
    checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL bp_stable got %h want 00000011", out_data); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin errors++; $display("FAIL bp_second got v=%b d=%h want v=1 d=00000022", out_valid, out_data); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_c_dropped got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_s [4];
    exp_s = '{32'h11, 32'h22, 32'h33, 32'h44};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== exp_s[i]) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b r=%b d=%h want v=1 r=1 d=%h", i, out_valid, in_ready, out_data, exp_s[i]);
      end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick;
    sel = 2'd1;
    tick;
    flush = 1'b1; sel = 2'd3;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_beat got %b want 0", out_valid); end
    // Ready is high here, so the flush alone must discard the offered beat.
    fl3 = 1'b1; iv3 = 1'b1; s3 = 2'd3;
    tick;
    fl3 = 1'b0; iv3 = 1'b0;
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL flush_empty_drop got %b want 0", ov3); end
    checks++; if (se3 !== 1'b0) begin errors++; $display("FAIL flush_no_err got %b want 0", se3); end
  endtask

  task automatic test_async_reset;
    s3 = 2'd3; iv3 = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick;
    iv3 = 1'b0; sel = 2'd1;
    tick;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || se3 !== 1'b1) begin errors++; $display("FAIL ar_setup got r=%b e=%b want r=0 e=1", in_ready, se3); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_ready got %b want 0", in_ready); end
    checks++; if (se3 !== 1'b0) begin errors++; $display("FAIL ar_sel_err got %b want 0", se3); end
    checks++; if (out_data !== DEF4) begin errors++; $display("FAIL ar_data got %h want %h", out_data, DEF4); end
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    rst = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin errors++; $display("FAIL ar_new_beat got v=%b d=%h want v=1 d=00000033", out_valid, out_data); end
    tick;
  endtask

  initial begin
    d_in = {32'h44, 32'h33, 32'h22, 32'h11};
    sel = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_err = 1'b0;
    d3 = {32'h333, 32'h222, 32'h111};
    s3 = '0; iv3 = 1'b0; or3 = 1'b0; fl3 = 1'b0; clr3 = 1'b0;
    test_reset;
    test_single;
    test_sel_err;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
